// File: rtl/adder_pkg.sv
// Shared register map, response codes and status bit positions for the adder slave.
// Optional subtract mode is enabled with the ADDER_SUB_EN macro.
package adder_pkg;

  localparam logic [7:0] ADDR_A      = 8'h00;
  localparam logic [7:0] ADDR_B      = 8'h04;
  localparam logic [7:0] ADDR_SUM    = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_MODE   = 8'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATUS_CARRY_BIT = 0;
  localparam int STATUS_OVF_BIT   = 1;

  typedef enum logic [2:0] {
    REG_A,
    REG_B,
    REG_SUM,
    REG_STATUS,
    REG_MODE,
    REG_NONE
  } reg_sel_e;

endpackage

// File: rtl/adder_core.sv
// Combinational add/subtract datapath: sum, carry (borrow when subtracting) and signed overflow.
module adder_core #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  // Subtraction is a + ~b + 1; the raw carry out is then the inverse of borrow.
  always_comb begin
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  end

  assign sum      = full[W-1:0];
  assign carry    = full[W] ^ sub;
  assign overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/adder.sv
// AXI4-Lite slave holding operands A/B and exposing SUM/STATUS as read-only registers.
// Defining ADDER_SUB_EN adds a MODE register at 0x10 selecting subtraction.
module adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // AW and W are accepted together in one cycle; B and R are held until their ready.

  logic [DATA_WIDTH-1:0] reg_a;
  logic [DATA_WIDTH-1:0] reg_b;
  logic                  mode_sub;
  logic [DATA_WIDTH-1:0] sum;
  logic                  carry;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] status;

  adder_core #(.W(DATA_WIDTH)) u_core (
    .a        (reg_a),
    .b        (reg_b),
    .sub      (mode_sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always_comb begin
    status                   = '0;
    status[STATUS_CARRY_BIT] = carry;
    status[STATUS_OVF_BIT]   = overflow;
  end

  function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] w;
    w = {addr[ADDR_WIDTH-1:2], 2'b00};
    if (w == ADDR_WIDTH'(ADDR_A))      return REG_A;
    if (w == ADDR_WIDTH'(ADDR_B))      return REG_B;
    if (w == ADDR_WIDTH'(ADDR_SUM))    return REG_SUM;
    if (w == ADDR_WIDTH'(ADDR_STATUS)) return REG_STATUS;
`ifdef ADDER_SUB_EN
    if (w == ADDR_WIDTH'(ADDR_MODE))   return REG_MODE;
`endif
    return REG_NONE;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0]   old,
    input logic [DATA_WIDTH-1:0]   data,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb[i]) r[i*8 +: 8] = data[i*8 +: 8];
    end
    return r;
  endfunction

  logic     wr_fire;
  logic     rd_fire;
  reg_sel_e wr_sel;
  reg_sel_e rd_sel;

  assign wr_fire = s1_axi_awready && s1_axi_awvalid && s1_axi_wvalid;
  assign rd_fire = s1_axi_arready && s1_axi_arvalid;
  assign wr_sel  = decode(s1_axi_awaddr);
  assign rd_sel  = decode(s1_axi_araddr);

  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      REG_A:      rd_data = reg_a;
      REG_B:      rd_data = reg_b;
      REG_SUM:    rd_data = sum;
      REG_STATUS: rd_data = status;
      REG_MODE:   rd_data = {{(DATA_WIDTH-1){1'b0}}, mode_sub};
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge s1_axi_aclk) begin
    if (!s1_axi_aresetn) begin
      s1_axi_awready <= 1'b0;
      s1_axi_wready  <= 1'b0;
      s1_axi_bvalid  <= 1'b0;
      s1_axi_bresp   <= RESP_OKAY;
      reg_a          <= '0;
      reg_b          <= '0;
    end else begin
      s1_axi_awready <= s1_axi_awvalid && s1_axi_wvalid && !s1_axi_bvalid && !s1_axi_awready;
      s1_axi_wready  <= s1_axi_awvalid && s1_axi_wvalid && !s1_axi_bvalid && !s1_axi_awready;
      if (wr_fire) begin
        s1_axi_bvalid <= 1'b1;
        s1_axi_bresp  <= (wr_sel == REG_A || wr_sel == REG_B || wr_sel == REG_MODE)
                         ? RESP_OKAY : RESP_SLVERR;
        if (wr_sel == REG_A) reg_a <= merge(reg_a, s1_axi_wdata, s1_axi_wstrb);
        if (wr_sel == REG_B) reg_b <= merge(reg_b, s1_axi_wdata, s1_axi_wstrb);
      end else if (s1_axi_bvalid && s1_axi_bready) begin
        s1_axi_bvalid <= 1'b0;
      end
    end
  end

`ifdef ADDER_SUB_EN
  always_ff @(posedge s1_axi_aclk) begin
    if (!s1_axi_aresetn) begin
      mode_sub <= 1'b0;
    end else if (wr_fire && wr_sel == REG_MODE && s1_axi_wstrb[0]) begin
      mode_sub <= s1_axi_wdata[0];
    end
  end
`else
  assign mode_sub = 1'b0;
`endif

  // Read data is captured from the current register values, so a write landing on
  // the same edge is only visible to the following read.
  always_ff @(posedge s1_axi_aclk) begin
    if (!s1_axi_aresetn) begin
      s1_axi_arready <= 1'b0;
      s1_axi_rvalid  <= 1'b0;
      s1_axi_rdata   <= '0;
      s1_axi_rresp   <= RESP_OKAY;
    end else begin
      s1_axi_arready <= s1_axi_arvalid && !s1_axi_rvalid && !s1_axi_arready;
      if (rd_fire) begin
        s1_axi_rvalid <= 1'b1;
        s1_axi_rdata  <= rd_data;
        s1_axi_rresp  <= rd_resp;
      end else if (s1_axi_rvalid && s1_axi_rready) begin
        s1_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for the adder AXI-Lite slave: directed register-map cases plus random traffic.
module tb_adder;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  adder dut (
    .s1_axi_aclk    (clk),
    .s1_axi_aresetn (aresetn),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  exp_rresp_q[$];
  logic [1:0]  exp_bresp_q[$];

  // Reference model state
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_sub;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [31:0] model_sum();
    return m_sub ? (m_a - m_b) : (m_a + m_b);
  endfunction

  function automatic logic [31:0] model_status();
    longint sa;
    longint sb;
    longint r;
    longint unsigned u;
    logic c;
    logic v;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    if (m_sub) begin
      c = (m_a < m_b);
      r = sa - sb;
    end else begin
      u = 64'(m_a) + 64'(m_b);
      c = (u > 64'hFFFF_FFFF);
      r = sa + sb;
    end
    v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {30'd0, v, c};
  endfunction

  function automatic logic map_mode();
`ifdef ADDER_SUB_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic [7:0] w;
    w = {addr[7:2], 2'b00};
    d = 32'd0;
    r = RESP_OKAY;
    if (w == ADDR_A) d = m_a;
    else if (w == ADDR_B) d = m_b;
    else if (w == ADDR_SUM) d = model_sum();
    else if (w == ADDR_STATUS) d = model_status();
    else if (w == ADDR_MODE && map_mode()) d = {31'd0, m_sub};
    else r = RESP_SLVERR;
  endtask

  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [7:0] w;
    w = {addr[7:2], 2'b00};
    if (w == ADDR_A) begin m_a = strb_merge(m_a, d, s); return RESP_OKAY; end
    if (w == ADDR_B) begin m_b = strb_merge(m_b, d, s); return RESP_OKAY; end
    if (w == ADDR_MODE && map_mode()) begin
      if (s[0]) m_sub = d[0];
      return RESP_OKAY;
    end
    return RESP_SLVERR;
  endfunction

  // Monitor: pops the expected queues whenever a response completes
  logic awready_prev = 1'b0;
  always @(negedge clk) begin
    if (aresetn) begin
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          check("r_unexpected", 32'd1, 32'd0);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
          check("rresp", 32'(rresp), 32'(exp_rresp_q.pop_front()));
        end
      end
      if (bvalid && bready) begin
        if (exp_bresp_q.size() == 0) check("b_unexpected", 32'd1, 32'd0);
        else check("bresp", 32'(bresp), 32'(exp_bresp_q.pop_front()));
      end
      if (awready || wready) begin
        check("aw_w_pair", 32'({awready, wready}), 32'b11);
        check("aw_pulse_prev", 32'(awready_prev), 32'd0);
      end
    end
    awready_prev = awready;
  end

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] s,
                           input bit wait_resp);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      if (awready) break;
      n++;
    end
    if (n >= 20) begin
      timeout("aw_timeout");
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    exp_bresp_q.push_back(model_write(addr, d, s));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (wait_resp) begin
      n = 0;
      while (bvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (bvalid) timeout("b_timeout");
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, input bit wait_resp, input bit use_exp,
                          input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n;
    logic [31:0] md;
    logic [1:0] mr;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      if (arready) break;
      n++;
    end
    if (n >= 20) begin
      timeout("ar_timeout");
      arvalid = 1'b0;
      return;
    end
    model_read(addr, md, mr);
    exp_q.push_back(use_exp ? exp_d : md);
    exp_rresp_q.push_back(use_exp ? exp_r : mr);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (wait_resp) begin
      n = 0;
      while (rvalid && n < 20) begin @(posedge clk); #1; n++; end
      if (rvalid) timeout("r_timeout");
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_awready"}, 32'(awready), 32'd0);
    check({tag, "_wready"},  32'(wready),  32'd0);
    check({tag, "_bvalid"},  32'(bvalid),  32'd0);
    check({tag, "_bresp"},   32'(bresp),   32'd0);
    check({tag, "_arready"}, 32'(arready), 32'd0);
    check({tag, "_rvalid"},  32'(rvalid),  32'd0);
    check({tag, "_rdata"},   rdata,        32'd0);
    check({tag, "_rresp"},   32'(rresp),   32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    aresetn = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("reset");
    exp_q.delete(); exp_rresp_q.delete(); exp_bresp_q.delete();
    m_a = '0; m_b = '0; m_sub = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    m_a = '0; m_b = '0; m_sub = 1'b0;
    repeat (3) @(posedge clk);
    apply_reset();

    // Basic add
    axi_write(ADDR_A, 32'd23, 4'hF, 1);
    axi_write(ADDR_B, 32'd30, 4'hF, 1);
    axi_read(ADDR_SUM, 1, 1, 32'd53, RESP_OKAY);
    axi_read(ADDR_STATUS, 1, 1, 32'd0, RESP_OKAY);
    axi_write(ADDR_A, 32'd37, 4'hF, 1);
    axi_write(ADDR_B, 32'd44, 4'hF, 1);
    axi_read(ADDR_SUM, 1, 1, 32'd81, RESP_OKAY);
    axi_read(ADDR_STATUS, 1, 1, 32'd0, RESP_OKAY);

    // Carry and signed overflow boundaries
    axi_write(ADDR_A, 32'hFFFF_FFFF, 4'hF, 1);
    axi_write(ADDR_B, 32'd1, 4'hF, 1);
    axi_read(ADDR_SUM, 1, 1, 32'd0, RESP_OKAY);
    axi_read(ADDR_STATUS, 1, 1, 32'h1, RESP_OKAY);
    axi_write(ADDR_A, 32'h7FFF_FFFF, 4'hF, 1);
    axi_read(ADDR_SUM, 1, 1, 32'h8000_0000, RESP_OKAY);
    axi_read(ADDR_STATUS, 1, 1, 32'h2, RESP_OKAY);

    // Byte strobes and ignored low address bits
    axi_write(ADDR_A, 32'h1122_3344, 4'hF, 1);
    axi_write(8'h02, 32'hAABB_CCDD, 4'h5, 1);
    axi_read(8'h03, 1, 1, 32'h11BB_33DD, RESP_OKAY);

    // SLVERR write with stalled B channel
    bready = 1'b0;
    axi_write(ADDR_SUM, 32'h1234_5678, 4'hF, 0);
    repeat (3) begin
      @(negedge clk);
      check("b_stall_valid", 32'(bvalid), 32'd1);
      check("b_stall_resp", 32'(bresp), 32'(RESP_SLVERR));
    end
    @(posedge clk); #1; bready = 1'b1;
    @(posedge clk); #1;
    check("b_cleared", 32'(bvalid), 32'd0);
    axi_read(ADDR_SUM, 1, 1, 32'h11BB_33DE, RESP_OKAY);

    // Unmapped read with stalled R channel
    rready = 1'b0;
    axi_read(8'h20, 0, 1, 32'd0, RESP_SLVERR);
    repeat (3) begin
      @(negedge clk);
      check("r_stall_valid", 32'(rvalid), 32'd1);
      check("r_stall_data", rdata, 32'd0);
      check("r_stall_resp", 32'(rresp), 32'(RESP_SLVERR));
    end
    @(posedge clk); #1; rready = 1'b1;
    @(posedge clk); #1;
    check("r_cleared", 32'(rvalid), 32'd0);

`ifdef ADDER_SUB_EN
    axi_write(ADDR_MODE, 32'd1, 4'hF, 1);
    axi_write(ADDR_A, 32'd5, 4'hF, 1);
    axi_write(ADDR_B, 32'd7, 4'hF, 1);
    axi_read(ADDR_SUM, 1, 1, 32'hFFFF_FFFE, RESP_OKAY);
    axi_read(ADDR_STATUS, 1, 1, 32'h1, RESP_OKAY);
    axi_read(ADDR_MODE, 1, 1, 32'h1, RESP_OKAY);
`else
    axi_write(ADDR_MODE, 32'd1, 4'hF, 1);
    axi_read(ADDR_MODE, 1, 1, 32'd0, RESP_SLVERR);
`endif

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      logic [7:0] addr;
      addr = {$urandom_range(0, 8), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1)
        axi_write(addr, $urandom, 4'($urandom_range(0, 15)), 1);
      else
        axi_read(addr, 1, 0, 32'd0, RESP_OKAY);
    end
    axi_read(ADDR_SUM, 1, 0, 32'd0, RESP_OKAY);
    axi_read(ADDR_STATUS, 1, 0, 32'd0, RESP_OKAY);

    // Reset during pending read and write handshakes
    axi_write(ADDR_A, 32'hCAFE_0001, 4'hF, 1);
    @(negedge clk);
    araddr = ADDR_A; arvalid = 1'b1;
    awaddr = ADDR_B; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    apply_reset();
    axi_read(ADDR_A, 1, 1, 32'd0, RESP_OKAY);
    axi_read(ADDR_B, 1, 1, 32'd0, RESP_OKAY);

    // Reset while a write response is stalled
    bready = 1'b0;
    axi_write(ADDR_B, 32'h0000_00FF, 4'hF, 0);
    apply_reset();
    axi_read(ADDR_B, 1, 1, 32'd0, RESP_OKAY);
    axi_read(ADDR_SUM, 1, 1, 32'd0, RESP_OKAY);

    repeat (4) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("exp_bresp_q_empty", 32'(exp_bresp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
